// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 hex keypad (Pmod KYPD) scanner on the 1 kHz tick.
// Drives one active-low column per cycle, samples the active-low rows on
// the edge that ends each column period, debounces whole scans, rejects
// multi-key ghosts and shifts accepted digits into a 16-bit entry register.
// Build option: define KEYPAD_AUTOREPEAT_EN to re-issue the held key every
// REPEAT_SCANS scans; without it exactly one key_valid is issued per press.
module keypad_scanner #(
    parameter int unsigned DEBOUNCE_SCANS = 4,   // 1..15
    parameter int unsigned REPEAT_SCANS   = 125  // 1..255, auto-repeat only
) (
    input  logic        clk_1khz,
    input  logic        reset_n,
    input  logic [3:0]  row_n,
    input  logic        clear,
    output logic [3:0]  col_n,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic [15:0] entry_value
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_HELD,
        ST_REL_DB
    } state_t;

    localparam logic [3:0] DB_LIMIT = 4'(DEBOUNCE_SCANS);

    // Out-of-range parameters leave this marker block in the elaborated tree.
    if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15 ||
        REPEAT_SCANS < 1 || REPEAT_SCANS > 255) begin : g_param_out_of_range
    end

    logic [1:0]  col_idx_q;
    logic [1:0]  acc_cnt_q;      // hit count so far, saturates at 2 (MULTI)
    logic [3:0]  acc_code_q;     // code of the first hit in scan order
    logic [1:0]  acc_cnt_d;
    logic [3:0]  acc_code_d;
    state_t      state_q;
    logic [3:0]  cand_q;
    logic [3:0]  cnt_q;
    logic [3:0]  key_code_q;
    logic        key_valid_q;
    logic        key_held_q;
    logic [15:0] entry_q;

    logic [3:0]  row_low;
    logic [2:0]  col_hits;
    logic [1:0]  first_row;
    logic [1:0]  base_cnt;
    logic [3:0]  base_code;
    logic [2:0]  sum_hits;
    logic        scan_done;
    logic        scan_none;
    logic        scan_single;
    logic        accept;
    logic        shift;
    logic [3:0]  shift_code;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam logic [7:0] RPT_LIMIT = 8'(REPEAT_SCANS);
    logic [7:0] rpt_cnt_q;
    logic       repeat_fire;
`endif

    // Keypad legend, row r / column c.
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'b0000: key_map = 4'h1;
            4'b0001: key_map = 4'h2;
            4'b0010: key_map = 4'h3;
            4'b0011: key_map = 4'hA;
            4'b0100: key_map = 4'h4;
            4'b0101: key_map = 4'h5;
            4'b0110: key_map = 4'h6;
            4'b0111: key_map = 4'hB;
            4'b1000: key_map = 4'h7;
            4'b1001: key_map = 4'h8;
            4'b1010: key_map = 4'h9;
            4'b1011: key_map = 4'hC;
            4'b1100: key_map = 4'h0;
            4'b1101: key_map = 4'hF;
            4'b1110: key_map = 4'hE;
            default: key_map = 4'hD;
        endcase
    endfunction

    assign col_n       = ~(4'b0001 << col_idx_q);
    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;
    assign key_held    = key_held_q;
    assign entry_value = entry_q;

    // Fold the current column's row sample into the running scan result;
    // column 0 starts a fresh scan, column 3 completes it.
    always_comb begin
        row_low   = ~row_n;
        col_hits  = {2'b00, row_low[0]} + {2'b00, row_low[1]} +
                    {2'b00, row_low[2]} + {2'b00, row_low[3]};
        first_row = row_low[0] ? 2'd0 :
                    row_low[1] ? 2'd1 :
                    row_low[2] ? 2'd2 : 2'd3;
        base_cnt  = (col_idx_q == 2'd0) ? 2'd0 : acc_cnt_q;
        base_code = (col_idx_q == 2'd0) ? 4'h0 : acc_code_q;
        sum_hits  = {1'b0, base_cnt} + col_hits;
        acc_cnt_d = (sum_hits >= 3'd2) ? 2'd2 : sum_hits[1:0];
        acc_code_d = (base_cnt == 2'd0) ? key_map(first_row, col_idx_q) : base_code;
        scan_done   = (col_idx_q == 2'd3);
        scan_none   = (acc_cnt_d != 2'd1);   // MULTI counts as no key outside HELD
        scan_single = (acc_cnt_d == 2'd1);
    end

    // Accept decision for the scan being evaluated on this edge.
    always_comb begin
        accept = 1'b0;
        if (scan_done && scan_single) begin
            if (state_q == ST_IDLE && DB_LIMIT <= 4'd1)
                accept = 1'b1;
            else if (state_q == ST_DEBOUNCE && acc_code_d == cand_q &&
                     (cnt_q + 4'd1) >= DB_LIMIT)
                accept = 1'b1;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    // A held key re-fires once its repeat counter reaches the limit.
    always_comb begin
        repeat_fire = scan_done && scan_single && (state_q == ST_HELD) &&
                      (acc_code_d == key_code_q) && ((rpt_cnt_q + 8'd1) == RPT_LIMIT);
        shift       = accept | repeat_fire;
        shift_code  = accept ? acc_code_d : key_code_q;
    end
`else
    // Only a debounced press produces a digit.
    always_comb begin
        shift      = accept;
        shift_code = acc_code_d;
    end
`endif

    // Column counter and scan accumulator.
    always_ff @(posedge clk_1khz or negedge reset_n) begin
        if (!reset_n) begin
            col_idx_q  <= '0;
            acc_cnt_q  <= '0;
            acc_code_q <= '0;
        end else begin
            col_idx_q  <= col_idx_q + 2'd1;
            acc_cnt_q  <= acc_cnt_d;
            acc_code_q <= acc_code_d;
        end
    end

    // Press/release debounce FSM, stepping only on scan-evaluation edges.
    always_ff @(posedge clk_1khz or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cand_q     <= '0;
            cnt_q      <= '0;
            key_held_q <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt_cnt_q  <= '0;
`endif
        end else if (scan_done) begin
            case (state_q)
                ST_IDLE: begin
                    if (scan_single) begin
                        cand_q <= acc_code_d;
                        cnt_q  <= 4'd1;
                        if (accept) begin
                            state_q    <= ST_HELD;
                            key_held_q <= 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rpt_cnt_q  <= '0;
`endif
                        end else begin
                            state_q <= ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (accept) begin
                        state_q    <= ST_HELD;
                        key_held_q <= 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rpt_cnt_q  <= '0;
`endif
                    end else if (scan_single && acc_code_d == cand_q) begin
                        cnt_q <= cnt_q + 4'd1;
                    end else if (scan_single) begin
                        cand_q <= acc_code_d;
                        cnt_q  <= 4'd1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_HELD: begin
                    if (acc_cnt_d == 2'd0) begin
                        cnt_q <= 4'd1;
                        if (DB_LIMIT <= 4'd1) begin
                            state_q    <= ST_IDLE;
                            key_held_q <= 1'b0;
                        end else begin
                            state_q <= ST_REL_DB;
                        end
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    if (scan_single && acc_code_d == key_code_q && !repeat_fire)
                        rpt_cnt_q <= rpt_cnt_q + 8'd1;
                    else
                        rpt_cnt_q <= '0;
`endif
                end
                default: begin // ST_REL_DB
                    if (acc_cnt_d == 2'd0) begin
                        if ((cnt_q + 4'd1) >= DB_LIMIT) begin
                            state_q    <= ST_IDLE;
                            key_held_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end else begin
                        state_q <= ST_HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rpt_cnt_q <= '0;
`endif
                    end
                end
            endcase
        end
    end

    // Registered key outputs and entry shift register; clear wins over a shift.
    always_ff @(posedge clk_1khz or negedge reset_n) begin
        if (!reset_n) begin
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            entry_q     <= '0;
        end else begin
            key_valid_q <= shift;
            if (shift)
                key_code_q <= shift_code;
            if (clear)
                entry_q <= '0;
            else if (shift)
                entry_q <= {entry_q[11:0], shift_code};
        end
    end

    // scan_none is kept for readability of the scan result decode.
    logic unused_ok;
    assign unused_ok = scan_none;

endmodule
